// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - vend request, hopper handshake and dispenser pulse bundle.
interface change_dispenser_if #(
    parameter int CHG_W = 4
);
    logic             vend_valid;
    logic [CHG_W-1:0] change_amt;
    logic             hopper_ready;
    logic             busy;
    logic             ticket_out;
    logic             coin5_out;
    logic             coin1_out;
    logic             done;
    logic [CHG_W-1:0] paid;

    modport master (
        output vend_valid, change_amt, hopper_ready,
        input  busy, ticket_out, coin5_out, coin1_out, done, paid
    );

    modport slave (
        input  vend_valid, change_amt, hopper_ready,
        output busy, ticket_out, coin5_out, coin1_out, done, paid
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - one ticket pulse, then greedy 5/1 coin pulses with recovery gaps.
module change_dispenser #(
    parameter int CHG_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             res,
    change_dispenser_if.slave bus
);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {IDLE, TICKET, GAP_WAIT, COIN, DONE} state_t;

    state_t           state, state_n;
    logic [CHG_W-1:0] rem, rem_n;
    logic [CHG_W-1:0] paid_q, paid_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             busy_q, busy_n;
    logic             ticket_q, ticket_n;
    logic             coin5_q, coin5_n;
    logic             coin1_q, coin1_n;
    logic             done_q, done_n;

    always_ff @(posedge clk) begin
        if (!res) begin
            state    <= IDLE;
            rem      <= '0;
            paid_q   <= '0;
            gap_cnt  <= '0;
            busy_q   <= 1'b0;
            ticket_q <= 1'b0;
            coin5_q  <= 1'b0;
            coin1_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            paid_q   <= paid_n;
            gap_cnt  <= gap_n;
            busy_q   <= busy_n;
            ticket_q <= ticket_n;
            coin5_q  <= coin5_n;
            coin1_q  <= coin1_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        paid_n   = paid_q;
        gap_n    = gap_cnt;
        busy_n   = busy_q;
        ticket_n = 1'b0;
        coin5_n  = 1'b0;
        coin1_n  = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.vend_valid) begin
                    rem_n   = bus.change_amt;
                    paid_n  = '0;
                    busy_n  = 1'b1;
                    state_n = TICKET;
                end
            end
            TICKET: begin
                if (bus.hopper_ready) begin
                    ticket_n = 1'b1;
                    gap_n    = GW'(GAP);
                    state_n  = GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                // The edge that sees the count at 1 is the last of the GAP idle edges.
                if (gap_cnt <= GW'(1)) begin
                    gap_n   = '0;
                    state_n = (rem != '0) ? COIN : DONE;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            COIN: begin
                if (bus.hopper_ready) begin
                    if (rem >= CHG_W'(5)) begin
                        coin5_n = 1'b1;
                        rem_n   = rem - CHG_W'(5);
                        paid_n  = paid_q + CHG_W'(5);
                    end else begin
                        coin1_n = 1'b1;
                        rem_n   = rem - CHG_W'(1);
                        paid_n  = paid_q + CHG_W'(1);
                    end
                    gap_n   = GW'(GAP);
                    state_n = GAP_WAIT;
                end
            end
            DONE: begin
                // Two edges here: the first raises done, the second drops busy.
                if (!done_q) begin
                    done_n = 1'b1;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.ticket_out = ticket_q;
    assign bus.coin5_out  = coin5_q;
    assign bus.coin1_out  = coin1_q;
    assign bus.done       = done_q;
    assign bus.paid       = paid_q;
endmodule
